// File: rtl/float_add_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float_add_writeback_pkg
// Description : Shared types and constants for the float_add_writeback engine:
//               FP word width, FSM state encoding, read-latency limits.
// Revision    : 1.0 - initial release
// ============================================================================
package float_add_writeback_pkg;

    // IEEE-754 single-precision word width; the adder datapath is fixed to it
    localparam int FP_W = 32;

    // Legal memory read latency range, in cycles
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Wait counter width: counts 0 .. RD_LAT_MAX-1
    localparam int WAIT_W = 2;

    // Canonical quiet NaN produced for invalid operations (inf - inf, NaN in)
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7fc0_0000;

    // Job sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_ADD   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage : float_add_writeback_pkg
`default_nettype wire

// File: rtl/float_adder.sv
`default_nettype none
// ============================================================================
// Module      : float_adder
// Description : Combinational IEEE-754 single-precision adder. Round to
//               nearest even, gradual underflow, overflow to infinity,
//               NaN / infinity propagation.
// Revision    : 1.0 - initial release
// ============================================================================
module float_adder
    import float_add_writeback_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] sum
);

    logic        a_big;
    logic        s_big;
    logic        eff_sub;
    logic [7:0]  e_big_raw;
    logic [7:0]  e_small_raw;
    logic [22:0] f_big;
    logic [22:0] f_small;
    logic [9:0]  e_big;
    logic [9:0]  e_small;
    logic [9:0]  e_diff;
    logic [9:0]  e_res;
    logic [9:0]  e_out;
    logic [9:0]  lshift;
    logic [26:0] m_big;
    logic [26:0] m_small;
    logic [26:0] m_align;
    logic [26:0] m_norm;
    logic [27:0] m_sum;
    logic [4:0]  lead;
    logic        sticky;
    logic        rnd_up;
    logic [24:0] m_rnd;
    logic [22:0] f_out;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;

    // Align, add/subtract, normalise and round; specials override at the end
    always_comb begin
        a_nan = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);

        // Magnitude ordering on the raw bit pattern is valid for IEEE-754
        a_big       = (a[30:0] >= b[30:0]);
        s_big       = a_big ? a[31]    : b[31];
        e_big_raw   = a_big ? a[30:23] : b[30:23];
        e_small_raw = a_big ? b[30:23] : a[30:23];
        f_big       = a_big ? a[22:0]  : b[22:0];
        f_small     = a_big ? b[22:0]  : a[22:0];
        eff_sub     = a[31] ^ b[31];

        // Subnormals use exponent 1 with no hidden bit
        e_big   = (e_big_raw   == 8'd0) ? 10'd1 : {2'b00, e_big_raw};
        e_small = (e_small_raw == 8'd0) ? 10'd1 : {2'b00, e_small_raw};
        m_big   = {(e_big_raw   != 8'd0), f_big,   3'b000};
        m_small = {(e_small_raw != 8'd0), f_small, 3'b000};
        e_diff  = e_big - e_small;

        // Right-align the smaller operand, folding lost bits into sticky
        if (e_diff > 10'd26) begin
            m_align = '0;
            sticky  = |m_small;
        end else begin
            m_align = m_small >> e_diff;
            sticky  = |(m_small & ~(27'h7ff_ffff << e_diff));
        end
        m_align[0] = m_align[0] | sticky;

        m_sum = eff_sub ? ({1'b0, m_big} - {1'b0, m_align})
                        : ({1'b0, m_big} + {1'b0, m_align});

        lead = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (m_sum[i]) begin
                lead = 5'(i);
            end
        end

        // Normalise; left shifts stop at exponent 1 so results can go subnormal
        lshift = 10'd0;
        if (m_sum[27]) begin
            m_norm = m_sum[27:1] | {26'd0, m_sum[0]};
            e_res  = e_big + 10'd1;
        end else begin
            lshift = 10'd26 - {5'd0, lead};
            if (lshift > (e_big - 10'd1)) begin
                lshift = e_big - 10'd1;
            end
            m_norm = m_sum[26:0] << lshift;
            e_res  = e_big - lshift;
        end

        rnd_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
        m_rnd  = {1'b0, m_norm[26:3]} + {24'd0, rnd_up};

        if (m_rnd[24]) begin
            e_out = e_res + 10'd1;
            f_out = m_rnd[23:1];
        end else begin
            e_out = m_rnd[23] ? e_res : 10'd0;
            f_out = m_rnd[22:0];
        end

        if (e_out >= 10'd255) begin
            sum = {s_big, 8'hff, 23'd0};
        end else begin
            sum = {s_big, e_out[7:0], f_out};
        end

        if (m_sum == 28'd0) begin
            sum = {a[31] & b[31], 31'd0};
        end

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            sum = FP_QNAN;
        end else if (a_inf) begin
            sum = a;
        end else if (b_inf) begin
            sum = b;
        end
    end

endmodule : float_adder
`default_nettype wire

// File: rtl/float_add_writeback.sv
`default_nettype none
// ============================================================================
// Module      : float_add_writeback
// Description : Job engine that reads element pairs from operand memories A
//               and B, adds them with float_adder and writes each sum into
//               the result memory. start launches a job, done closes it.
// Revision    : 1.0 - initial release
// ============================================================================
module float_add_writeback
    import float_add_writeback_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_a_addr,
    input  logic [DATA_W-1:0] mem_a_rdata,
    output logic [ADDR_W-1:0] mem_b_addr,
    input  logic [DATA_W-1:0] mem_b_rdata,
    output logic [ADDR_W-1:0] mem_s_addr,
    output logic [DATA_W-1:0] mem_s_wdata,
    output logic              mem_s_wrt,
    output logic              mem_s_mode
);

    // Elaboration-time guards on the parameter set
    if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
        $error("float_add_writeback: RD_LAT must be within 1..4");
    end
    if (DATA_W != FP_W) begin : g_bad_data_w
        $error("float_add_writeback: DATA_W must equal 32");
    end

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

    state_t              state_q,  state_d;
    logic [ADDR_W:0]     len_q,    len_d;
    logic [ADDR_W-1:0]   src_q,    src_d;
    logic [ADDR_W-1:0]   dst_q,    dst_d;
    logic [ADDR_W-1:0]   idx_q,    idx_d;
    logic [WAIT_W-1:0]   wait_q,   wait_d;
    logic [DATA_W-1:0]   op_a_q,   op_a_d;
    logic [DATA_W-1:0]   op_b_q,   op_b_d;
    logic [DATA_W-1:0]   sum_q,    sum_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                wrt_q,    wrt_d;

    logic [DATA_W-1:0]   adder_sum;
    logic [ADDR_W-1:0]   idx_inc;
    logic                last_elem;

    float_adder u_float_adder (
        .a   (op_a_q),
        .b   (op_b_q),
        .sum (adder_sum)
    );

    // Next-state and next-output logic for the job sequencer
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        src_d     = src_q;
        dst_d     = dst_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sum_d     = sum_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wrt_d     = 1'b0;

        idx_inc   = idx_q + 1'b1;
        last_elem = ({1'b0, idx_q} == (len_q - 1'b1));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (len != '0) begin
                        len_d     = len;
                        src_d     = src_base;
                        dst_d     = dst_base;
                        idx_d     = '0;
                        wait_d    = '0;
                        rd_addr_d = src_base;
                        state_d   = ST_READ;
                    end else begin
                        // Empty job: no memory traffic, just the done handshake
                        state_d = ST_DONE;
                    end
                end
            end

            ST_READ: begin
                // Read address is held from READ entry; data is valid on the last wait cycle
                if (wait_q == WAIT_LAST) begin
                    op_a_d  = mem_a_rdata;
                    op_b_d  = mem_b_rdata;
                    state_d = ST_ADD;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            ST_ADD: begin
                sum_d     = adder_sum;
                wr_addr_d = dst_q + idx_q;
                wrt_d     = 1'b1;
                state_d   = ST_WRITE;
            end

            ST_WRITE: begin
                if (last_elem) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    idx_d     = idx_inc;
                    wait_d    = '0;
                    rd_addr_d = src_q + idx_inc;
                    state_d   = ST_READ;
                end
            end

            ST_DONE: begin
                // Entered with done already pending from WRITE, or not yet
                // signalled for an empty job; in the latter case pulse it now
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; async reset aborts any job in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sum_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wrt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sum_q     <= sum_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wrt_q     <= wrt_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_a_addr  = rd_addr_q;
    assign mem_b_addr  = rd_addr_q;
    assign mem_s_addr  = wr_addr_q;
    assign mem_s_wdata = sum_q;
    assign mem_s_wrt   = wrt_q;
    // The result memory is only ever switched to write mode for the write strobe
    assign mem_s_mode  = wrt_q;

endmodule : float_add_writeback
`default_nettype wire

// File: tb/tb_float_add_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_add_writeback
// Description : Self-checking bench: behavioural operand/result memories,
//               directed jobs, scoreboard of expected result writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_add_writeback;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;
    localparam logic [31:0] SENTINEL = 32'hdead_beef;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_a_addr;
    logic [DATA_W-1:0] mem_a_rdata;
    logic [ADDR_W-1:0] mem_b_addr;
    logic [DATA_W-1:0] mem_b_rdata;
    logic [ADDR_W-1:0] mem_s_addr;
    logic [DATA_W-1:0] mem_s_wdata;
    logic              mem_s_wrt;
    logic              mem_s_mode;

    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    logic [31:0] mem_s [32];

    logic [36:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          wr_cnt  = 0;

    float_add_writeback #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .busy        (busy),
        .done        (done),
        .mem_a_addr  (mem_a_addr),
        .mem_a_rdata (mem_a_rdata),
        .mem_b_addr  (mem_b_addr),
        .mem_b_rdata (mem_b_rdata),
        .mem_s_addr  (mem_s_addr),
        .mem_s_wdata (mem_s_wdata),
        .mem_s_wrt   (mem_s_wrt),
        .mem_s_mode  (mem_s_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle read latency: data is valid within the cycle the address is held
    assign mem_a_rdata = mem_a[mem_a_addr];
    assign mem_b_rdata = mem_b[mem_b_addr];

    always @(posedge clk) begin
        if (mem_s_wrt && mem_s_mode) begin
            mem_s[mem_s_addr] = mem_s_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every presented write must match the oldest expectation
    always @(negedge clk) begin
        logic [36:0] e;
        if (mem_s_wrt || mem_s_mode)
            check("wrt_mode_pair", {63'd0, mem_s_mode}, {63'd0, mem_s_wrt});
        if (busy)
            check("ab_addr_equal", {59'd0, mem_a_addr}, {59'd0, mem_b_addr});
        if (mem_s_wrt) begin
            if (exp_q.size() == 0) begin
                check("write_unexpected", {27'd0, mem_s_addr, mem_s_wdata}, 64'hffff_ffff_ffff_ffff);
            end else begin
                e = exp_q.pop_front();
                check("write", {27'd0, mem_s_addr, mem_s_wdata}, {27'd0, e});
            end
        end
    end

    task automatic expect_write(input logic [4:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic run_job(input string name, input logic [5:0] l, input logic [4:0] s,
                           input logic [4:0] d, input int exp_lat, input int exp_busy,
                           input int restart_at);
        int lat;
        int busy_cnt;
        int w0;
        bit seen;
        w0 = wr_cnt;
        @(negedge clk);
        len = l; src_base = s; dst_base = d; start = 1'b1;
        lat = 0; busy_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            lat++;
            start = (restart_at != 0) && (lat == restart_at);
            if (start) begin
                len = 6'd5; src_base = 5'd0; dst_base = 5'd0;
            end
            if (lat == 1) check({name, "_busy_rise"}, {63'd0, busy}, 64'd1);
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({name, "_done_latency"}, seen ? 64'(lat) : 64'hffff, 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({name, "_write_count"}, 64'(wr_cnt - w0), 64'(l));
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int w0;
        bit hit;
        rst = 1'b0; start = 1'b0; len = '0; src_base = '0; dst_base = '0;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
            mem_s[i] = SENTINEL;
        end
        // 1.0 + 1.0
        mem_a[2] = 32'h3f80_0000; mem_b[2] = 32'h3f80_0000;
        // Three-element burst at 8..10
        mem_a[8]  = 32'h3f80_0000; mem_b[8]  = 32'h3f80_0000;
        mem_a[9]  = 32'h4020_0000; mem_b[9]  = 32'h3f00_0000;
        mem_a[10] = 32'h3f80_0000; mem_b[10] = 32'hbf80_0000;
        // Wrap job reading 31, 0, 1
        mem_a[31] = 32'h3f80_0000; mem_b[31] = 32'h4000_0000;
        mem_a[0]  = 32'h4040_0000; mem_b[0]  = 32'h3f80_0000;
        mem_a[1]  = 32'hc000_0000; mem_b[1]  = 32'h3f80_0000;
        // Operands for the restart and abort jobs at 16..18
        mem_a[16] = 32'h3f80_0000; mem_b[16] = 32'h3f80_0000;
        mem_a[17] = 32'h4000_0000; mem_b[17] = 32'h3f80_0000;
        mem_a[18] = 32'h4040_0000; mem_b[18] = 32'h3f80_0000;

        repeat (3) @(negedge clk);
        check("rst_busy",  {63'd0, busy},       64'd0);
        check("rst_done",  {63'd0, done},       64'd0);
        check("rst_wrt",   {63'd0, mem_s_wrt},  64'd0);
        check("rst_mode",  {63'd0, mem_s_mode}, 64'd0);
        check("rst_a_addr", {59'd0, mem_a_addr}, 64'd0);
        check("rst_b_addr", {59'd0, mem_b_addr}, 64'd0);
        check("rst_s_addr", {59'd0, mem_s_addr}, 64'd0);
        check("rst_wdata", {32'd0, mem_s_wdata}, 64'd0);
        rst = 1'b1;

        // Single element: done RD_LAT+3 cycles after start
        expect_write(5'd3, 32'h4000_0000);
        run_job("one_plus_one", 6'd1, 5'd2, 5'd3, RD_LAT + 3, RD_LAT + 2, 0);
        check("one_plus_one_mem", {32'd0, mem_s[3]}, {32'd0, 32'h4000_0000});

        // Three-element burst: busy for 9 cycles, done at 10
        expect_write(5'd8,  32'h4000_0000);
        expect_write(5'd9,  32'h4040_0000);
        expect_write(5'd10, 32'h0000_0000);
        run_job("burst3", 6'd3, 5'd8, 5'd8, 10, 9, 0);

        // Empty job: done 2 cycles after start, no writes
        run_job("len0", 6'd0, 5'd4, 5'd4, 2, 1, 0);
        check("len0_mem_untouched", {32'd0, mem_s[4]}, {32'd0, SENTINEL});

        // Address wrap
        expect_write(5'd30, 32'h4040_0000);
        expect_write(5'd31, 32'h4080_0000);
        expect_write(5'd0,  32'hbf80_0000);
        run_job("wrap", 6'd3, 5'd31, 5'd30, 10, 9, 0);

        // start pulsed mid-job is ignored
        expect_write(5'd12, 32'h4000_0000);
        expect_write(5'd13, 32'h4040_0000);
        run_job("restart_ignored", 6'd2, 5'd16, 5'd12, 7, 6, 3);

        // Reset during WRITE of element 1 of 3
        expect_write(5'd20, 32'h4000_0000);
        w0 = wr_cnt;
        @(negedge clk);
        len = 6'd3; src_base = 5'd16; dst_base = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (mem_s_wrt && (wr_cnt - w0 == 1)) hit = 1'b1;
        end
        check("abort_reached_write1", {63'd0, hit}, 64'd1);
        #1 rst = 1'b0;
        #1;
        check("abort_busy",  {63'd0, busy},       64'd0);
        check("abort_wrt",   {63'd0, mem_s_wrt},  64'd0);
        check("abort_mode",  {63'd0, mem_s_mode}, 64'd0);
        check("abort_s_addr", {59'd0, mem_s_addr}, 64'd0);
        check("abort_wdata", {32'd0, mem_s_wdata}, 64'd0);
        repeat (2) @(negedge clk);
        check("abort_no_done", {63'd0, done}, 64'd0);
        rst = 1'b1;
        check("abort_write_count", 64'(wr_cnt - w0), 64'd1);
        check("abort_elem1_untouched", {32'd0, mem_s[21]}, {32'd0, SENTINEL});

        expect_write(5'd24, 32'h4000_0000);
        run_job("after_abort", 6'd1, 5'd16, 5'd24, RD_LAT + 3, RD_LAT + 2, 0);
        check("after_abort_elem2_untouched", {32'd0, mem_s[22]}, {32'd0, SENTINEL});
        check("after_abort_elem1_untouched", {32'd0, mem_s[21]}, {32'd0, SENTINEL});

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_float_add_writeback
`default_nettype wire
